// File: rtl/nn_pkg.sv
// Shared widths, layer geometry and controller state encoding for the
// neural-network propagation block.
package nn_pkg;
  localparam int LAYER_W  = 16;
  localparam int DATA_W   = 24;
  localparam int FRAC_W   = 12;
  localparam int ACC_W    = 56;
  localparam int STOR_AW  = 17;
  localparam int CONS_AW  = 8;
  localparam int IDX_W    = $clog2(LAYER_W);
  localparam int LAYER_SZ = LAYER_W * LAYER_W + LAYER_W;

  typedef enum logic [2:0] {
    IDLE,
    BIAS,
    MAC,
    DRAIN,
    WRITE,
    DONE
  } state_e;
endpackage

// File: rtl/nn_mac.sv
// Neuron datapath: registered multiply, 56-bit accumulate, then floor shift,
// saturation and optional ReLU into a registered output word.
module nn_mac
  import nn_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     bias_vld_i,
  input  logic                     mul_vld_i,
  input  logic                     last_i,
  input  logic                     relu_i,
  input  logic signed [DATA_W-1:0] st_rdata_i,
  input  logic signed [DATA_W-1:0] cons_rdata_i,
  output logic signed [DATA_W-1:0] y_o
);
  localparam logic signed [ACC_W-1:0] Y_MAX = ACC_W'(2 ** (DATA_W - 1) - 1);
  localparam logic signed [ACC_W-1:0] Y_MIN = ~Y_MAX;

  logic signed [2*DATA_W-1:0] prod_p1;
  logic                       vld_p1;
  logic                       last_p1;
  logic signed [ACC_W-1:0]    acc_q;
  logic signed [ACC_W-1:0]    acc_sum;
  logic signed [ACC_W-1:0]    bias_ext;
  logic signed [DATA_W-1:0]   y_q;

  function automatic logic signed [DATA_W-1:0] shift_sat(
    input logic signed [ACC_W-1:0] a,
    input logic                    relu
  );
    logic signed [ACC_W-1:0] s;
    s = a >>> FRAC_W;
    if (relu && s < 0)   return '0;
    else if (s > Y_MAX)  return {1'b0, {(DATA_W-1){1'b1}}};
    else if (s < Y_MIN)  return {1'b1, {(DATA_W-1){1'b0}}};
    else                 return s[DATA_W-1:0];
  endfunction

  assign bias_ext = $signed({{(ACC_W-DATA_W-FRAC_W){st_rdata_i[DATA_W-1]}},
                             st_rdata_i, {FRAC_W{1'b0}}});
  assign acc_sum  = acc_q + ACC_W'(prod_p1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_p1 <= '0;
      vld_p1  <= 1'b0;
      last_p1 <= 1'b0;
      acc_q   <= '0;
      y_q     <= '0;
    end else begin
      // p0 -> p1: operands from storage and activation RAM
      vld_p1  <= mul_vld_i;
      last_p1 <= mul_vld_i & last_i;
      if (mul_vld_i) prod_p1 <= st_rdata_i * cons_rdata_i;
      // p1 -> acc: bias load opens the neuron, last product closes it
      if (bias_vld_i)  acc_q <= bias_ext;
      else if (vld_p1) acc_q <= acc_sum;
      if (vld_p1 && last_p1) y_q <= shift_sat(acc_sum, relu_i);
    end
  end

  assign y_o = y_q;
endmodule

// File: rtl/nn_prop_ctrl.sv
// Layer-by-layer propagation controller: synchronises the HPS request, walks
// neurons/layers, drives storage and ping-pong activation RAM addressing.
module nn_prop_ctrl
  import nn_pkg::*;
(
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     prop,
  input  logic [7:0]               n_layers,
  output logic [STOR_AW-1:0]       st_addr,
  input  logic signed [DATA_W-1:0] st_rdata,
  output logic [CONS_AW-1:0]       cons_raddr,
  input  logic signed [DATA_W-1:0] cons_rdata,
  output logic [CONS_AW-1:0]       cons_waddr,
  output logic signed [DATA_W-1:0] cons_wdata,
  output logic                     cons_we,
  output logic                     busy,
  output logic                     done
);
  state_e             state_q;
  logic               sync1_q, sync2_q, prev_q;
  logic [1:0]         arm_cnt_q;
  logic               start_evt;
  logic               go_q, busy_q, done_q, cons_we_q;
  logic [7:0]         nl_q, layer_q;
  logic [IDX_W-1:0]   j_q, k_q, j_inc, k_inc;
  logic [STOR_AW-1:0] base_q, base_nxt, st_addr_q;
  logic [CONS_AW-1:0] cons_raddr_q, cons_waddr_q;
  logic               last_layer;

  function automatic logic [STOR_AW-1:0] w_addr(input logic [STOR_AW-1:0] base,
                                                input logic [IDX_W-1:0] j,
                                                input logic [IDX_W-1:0] k);
    return base + STOR_AW'({j, k});
  endfunction

  function automatic logic [STOR_AW-1:0] b_addr(input logic [STOR_AW-1:0] base,
                                                input logic [IDX_W-1:0] j);
    return base + STOR_AW'(LAYER_W * LAYER_W) + STOR_AW'(j);
  endfunction

  // Edges are only trusted once the synchroniser holds real samples, so a
  // request still high across reset release must fall and rise again.
  assign start_evt  = (arm_cnt_q == 2'd3) && sync2_q && !prev_q;
  assign j_inc      = j_q + IDX_W'(1);
  assign k_inc      = k_q + IDX_W'(1);
  assign base_nxt   = base_q + STOR_AW'(LAYER_SZ);
  assign last_layer = (layer_q == nl_q - 8'd1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      prev_q    <= 1'b0;
      arm_cnt_q <= '0;
    end else begin
      sync1_q <= prop;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (arm_cnt_q != 2'd3) arm_cnt_q <= arm_cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      go_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cons_we_q    <= 1'b0;
      nl_q         <= '0;
      layer_q      <= '0;
      j_q          <= '0;
      k_q          <= '0;
      base_q       <= '0;
      st_addr_q    <= '0;
      cons_raddr_q <= '0;
      cons_waddr_q <= '0;
    end else begin
      done_q    <= 1'b0;
      cons_we_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (go_q) begin
            go_q <= 1'b0;
            if (nl_q == 8'd0) begin
              state_q <= DONE;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
            end else begin
              state_q   <= BIAS;
              layer_q   <= '0;
              j_q       <= '0;
              base_q    <= '0;
              st_addr_q <= b_addr('0, '0);
            end
          end else if (start_evt && !busy_q) begin
            nl_q   <= n_layers;
            busy_q <= 1'b1;
            go_q   <= 1'b1;
          end
        end
        BIAS: begin
          state_q      <= MAC;
          k_q          <= '0;
          st_addr_q    <= w_addr(base_q, j_q, '0);
          cons_raddr_q <= CONS_AW'({layer_q[0], {IDX_W{1'b0}}});
        end
        MAC: begin
          if (k_q == IDX_W'(LAYER_W - 1)) begin
            state_q <= DRAIN;
            k_q     <= '0;
          end else begin
            k_q          <= k_inc;
            st_addr_q    <= w_addr(base_q, j_q, k_inc);
            cons_raddr_q <= CONS_AW'({layer_q[0], k_inc});
          end
        end
        DRAIN: begin
          if (k_q == IDX_W'(1)) begin
            state_q      <= WRITE;
            cons_we_q    <= 1'b1;
            cons_waddr_q <= CONS_AW'({~layer_q[0], j_q});
          end else begin
            k_q <= k_inc;
          end
        end
        WRITE: begin
          if (j_q != IDX_W'(LAYER_W - 1)) begin
            state_q   <= BIAS;
            j_q       <= j_inc;
            st_addr_q <= b_addr(base_q, j_inc);
          end else if (last_layer) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            state_q   <= BIAS;
            layer_q   <= layer_q + 8'd1;
            base_q    <= base_nxt;
            j_q       <= '0;
            st_addr_q <= b_addr(base_nxt, '0);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  nn_mac u_mac (
    .clk          (clk),
    .reset_n      (reset_n),
    .bias_vld_i   ((state_q == MAC) && (k_q == '0)),
    .mul_vld_i    (((state_q == MAC) && (k_q != '0)) || ((state_q == DRAIN) && (k_q == '0))),
    .last_i       ((state_q == DRAIN) && (k_q == '0)),
    .relu_i       (!last_layer),
    .st_rdata_i   (st_rdata),
    .cons_rdata_i (cons_rdata),
    .y_o          (cons_wdata)
  );

  assign st_addr    = st_addr_q;
  assign cons_raddr = cons_raddr_q;
  assign cons_waddr = cons_waddr_q;
  assign cons_we    = cons_we_q;
  assign busy       = busy_q;
  assign done       = done_q;
endmodule

// File: tb/tb_nn_prop_ctrl.sv
// Scoreboard bench for nn_prop_ctrl: directed runs push expected activation
// writes and run lengths; a monitor pops and compares on cons_we / done.
module tb_nn_prop_ctrl;
  logic               clk = 1'b0;
  logic               reset_n;
  logic               prop;
  logic [7:0]         n_layers;
  logic [16:0]        st_addr;
  logic signed [23:0] st_rdata;
  logic [7:0]         cons_raddr;
  logic signed [23:0] cons_rdata;
  logic [7:0]         cons_waddr;
  logic signed [23:0] cons_wdata;
  logic               cons_we;
  logic               busy;
  logic               done;

  logic signed [23:0] stor [0:1023];
  logic signed [23:0] cons_mem [0:255];
  logic               ld_we = 1'b0;
  logic [7:0]         ld_addr = '0;
  logic [23:0]        ld_data = '0;

  typedef struct packed { logic [7:0] addr; logic [23:0] data; } wr_t;
  wr_t wr_exp[$];
  int  done_exp[$];
  int  checks = 0;
  int  fails = 0;
  int  done_cnt = 0;
  int  run_cyc = 0;
  bit  running = 0;
  bit  busy_prev = 0;

  always #5 clk = ~clk;

  nn_prop_ctrl dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .prop       (prop),
    .n_layers   (n_layers),
    .st_addr    (st_addr),
    .st_rdata   (st_rdata),
    .cons_raddr (cons_raddr),
    .cons_rdata (cons_rdata),
    .cons_waddr (cons_waddr),
    .cons_wdata (cons_wdata),
    .cons_we    (cons_we),
    .busy       (busy),
    .done       (done)
  );

  always @(posedge clk) begin
    st_rdata   <= stor[st_addr[9:0]];
    cons_rdata <= cons_mem[cons_raddr];
    if (ld_we)        cons_mem[ld_addr] <= ld_data;
    else if (cons_we) cons_mem[cons_waddr] <= cons_wdata;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares every DUT write and every done pulse against the queues.
  always @(negedge clk) begin
    wr_t e;
    int  n;
    if (running) run_cyc++;
    if (busy && !busy_prev) begin
      running = 1;
      run_cyc = 0;
    end
    if (cons_we) begin
      if (wr_exp.size() == 0) chk("unexpected_write", {cons_waddr, cons_wdata}, 32'hFFFF_FFFF);
      else begin
        e = wr_exp.pop_front();
        chk("write_addr_data", {cons_waddr, cons_wdata}, {e.addr, e.data});
      end
    end
    if (done) begin
      done_cnt++;
      if (done_exp.size() == 0) chk("unexpected_done", 32'(run_cyc), 32'hFFFF_FFFF);
      else begin
        n = done_exp.pop_front();
        chk("run_length", 32'(run_cyc), 32'(n));
        chk("busy_low_in_done", {31'd0, busy}, 32'd0);
      end
      running = 0;
    end else if (!busy) begin
      running = 0;
    end
    busy_prev = busy;
  end

  task automatic clear_stor();
    for (int i = 0; i < 1024; i++) stor[i] = '0;
  endtask

  task automatic load_cons(input int a, input logic [23:0] d);
    ld_addr = 8'(a);
    ld_data = d;
    ld_we   = 1'b1;
    @(negedge clk);
    ld_we   = 1'b0;
  endtask

  task automatic push_layer(input int wbase, input logic [23:0] d);
    for (int j = 0; j < 16; j++) wr_exp.push_back({8'(wbase + j), d});
  endtask

  task automatic start_pulse(input logic [7:0] nl);
    n_layers = nl;
    prop = 1'b1;
    repeat (3) @(negedge clk);
    prop = 1'b0;
  endtask

  task automatic wait_done(input int start, input string nm);
    int cyc;
    cyc = 0;
    while (done_cnt == start && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    if (done_cnt == start) chk({nm, "_timeout"}, 32'd0, 32'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic run(input logic [7:0] nl, input string nm);
    int start;
    start = done_cnt;
    start_pulse(nl);
    wait_done(start, nm);
    chk({nm, "_idle_after"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int start;
    int cyc;
    reset_n  = 1'b0;
    prop     = 1'b0;
    n_layers = 8'd1;
    clear_stor();

    // Outputs stay zero under reset while the request toggles.
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      prop = ~prop;
      #1;
      chk("reset_outputs", {busy, done, cons_we, |st_addr, |cons_raddr, |cons_waddr, |cons_wdata},
          32'd0);
    end
    prop = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    // Identity weights: outputs equal inputs, written to the upper half.
    for (int j = 0; j < 16; j++) stor[j * 16 + j] = 24'h001000;
    for (int i = 0; i < 16; i++) load_cons(i, 24'(i * 4096));
    for (int j = 0; j < 16; j++) wr_exp.push_back({8'(16 + j), 24'(j * 4096)});
    done_exp.push_back(321);
    run(8'd1, "identity");

    // Positive and negative saturation on a linear last layer.
    clear_stor();
    for (int i = 0; i < 256; i++) stor[i] = 24'h7FFFFF;
    for (int i = 0; i < 16; i++) load_cons(i, 24'h7FFFFF);
    push_layer(16, 24'h7FFFFF);
    done_exp.push_back(321);
    run(8'd1, "sat_pos");
    for (int i = 0; i < 256; i++) stor[i] = 24'h800000;
    push_layer(16, 24'h800000);
    done_exp.push_back(321);
    run(8'd1, "sat_neg");

    // 0.5 * (-1 LSB) floors to -1 LSB rather than truncating to 0.
    clear_stor();
    for (int j = 0; j < 16; j++) stor[j * 16 + j] = 24'h000800;
    for (int i = 0; i < 16; i++) load_cons(i, 24'hFFFFFF);
    push_layer(16, 24'hFFFFFF);
    done_exp.push_back(321);
    run(8'd1, "floor");

    // Two layers: ReLU clamps layer 0, layer 1 bias lands in the lower half.
    clear_stor();
    for (int j = 0; j < 16; j++) stor[256 + j] = 24'hFFF000;
    for (int j = 0; j < 16; j++) stor[272 + 256 + j] = 24'h001000;
    push_layer(16, 24'h000000);
    push_layer(0, 24'h001000);
    done_exp.push_back(641);
    run(8'd2, "two_layer");

    // Zero layers: done right after busy, no writes.
    done_exp.push_back(1);
    run(8'd0, "zero_layers");

    // Re-toggling the request mid-run must not start a second run.
    push_layer(16, 24'hFFF000);
    done_exp.push_back(321);
    start = done_cnt;
    start_pulse(8'd1);
    repeat (50) @(negedge clk);
    prop = 1'b1;
    repeat (4) @(negedge clk);
    prop = 1'b0;
    wait_done(start, "retoggle");
    repeat (340) @(negedge clk);
    chk("retoggle_single_done", 32'(done_cnt - start), 32'd1);

    // Abort mid-run with the request held high across reset release.
    start_pulse(8'd1);
    prop = 1'b1;
    cyc = 0;
    while (!busy && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_busy_seen", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    reset_n = 1'b0;
    #1;
    chk("abort_outputs", {30'd0, busy, cons_we}, 32'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("held_prop_no_start", {31'd0, busy}, 32'd0);
    prop = 1'b0;
    repeat (4) @(negedge clk);
    push_layer(16, 24'hFFF000);
    done_exp.push_back(321);
    run(8'd1, "after_abort");

    chk("writes_drained", 32'(wr_exp.size()), 32'd0);
    chk("dones_drained", 32'(done_exp.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
